// File: rtl/wb_unified_mem_arbiter.sv
// Two-master Wishbone arbiter: shares one memory slave between the core's
// instruction bus (iwb) and data bus (dwb). Grants are held for the whole
// cyc_i envelope, and a watchdog aborts strobes that stall too long.
// Optional build macro ARB_ROUND_ROBIN_EN: ties go to the master not granted
// last, instead of the default fixed dwb priority.
module wb_unified_mem_arbiter #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] iwb_adr_i,
  input  logic              iwb_cyc_i,
  input  logic              iwb_stb_i,
  output logic [31:0]       iwb_dat_o,
  output logic              iwb_ack_o,
  output logic              iwb_err_o,
  input  logic [ADDR_W-1:0] dwb_adr_i,
  input  logic [31:0]       dwb_dat_i,
  input  logic              dwb_we_i,
  input  logic [3:0]        dwb_sel_i,
  input  logic              dwb_cyc_i,
  input  logic              dwb_stb_i,
  output logic [31:0]       dwb_dat_o,
  output logic              dwb_ack_o,
  output logic              dwb_err_o,
  output logic [ADDR_W-1:0] m_adr_o,
  output logic [31:0]       m_dat_o,
  output logic              m_we_o,
  output logic [3:0]        m_sel_o,
  output logic              m_cyc_o,
  output logic              m_stb_o,
  input  logic [31:0]       m_dat_i,
  input  logic              m_ack_i,
  input  logic              m_err_i,
  output logic [1:0]        grant_o
);

  typedef enum logic [1:0] {StIdle, StGrantI, StGrantD} state_e;

  // Keep the counter at least one bit wide when the watchdog is disabled.
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic WdtEn = (TIMEOUT_CYCLES > 0);

  state_e            state_q, state_d;
  logic [CntW-1:0]   wdt_q, wdt_d;
  logic              i_req, d_req;
  logic              d_wins;
  logic              timeout;
  logic              g_stb;

  assign i_req = iwb_cyc_i & iwb_stb_i;
  assign d_req = dwb_cyc_i & dwb_stb_i;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_grant_q;  // 1: dwb was granted last

  // Remember which master was granted most recently, for tie breaking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= 1'b0;
    end else if (state_d == StGrantI) begin
      last_grant_q <= 1'b0;
    end else if (state_d == StGrantD) begin
      last_grant_q <= 1'b1;
    end
  end

  assign d_wins = ~last_grant_q;
`else
  assign d_wins = 1'b1;
`endif

  assign timeout = WdtEn && (state_q != StIdle) && (wdt_q == CntW'(TIMEOUT_CYCLES));

  // State and watchdog registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      wdt_q   <= '0;
    end else begin
      state_q <= state_d;
      wdt_q   <= wdt_d;
    end
  end

  // Next-state: one-cycle arbitration from idle, direct hand-over on release.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (d_req && (!i_req || d_wins)) state_d = StGrantD;
        else if (i_req)                  state_d = StGrantI;
      end
      StGrantI: begin
        if (!iwb_cyc_i) state_d = d_req ? StGrantD : StIdle;
      end
      StGrantD: begin
        if (!dwb_cyc_i) state_d = i_req ? StGrantI : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Memory-side mux and response routing for the granted master.
  always_comb begin
    m_adr_o   = '0;
    m_dat_o   = '0;
    m_we_o    = 1'b0;
    m_sel_o   = 4'h0;
    m_cyc_o   = 1'b0;
    g_stb     = 1'b0;
    iwb_ack_o = 1'b0;
    iwb_err_o = 1'b0;
    dwb_ack_o = 1'b0;
    dwb_err_o = 1'b0;
    grant_o   = 2'b00;
    case (state_q)
      StGrantI: begin
        m_adr_o   = iwb_adr_i;
        m_sel_o   = 4'hF;
        m_cyc_o   = iwb_cyc_i;
        g_stb     = iwb_stb_i;
        iwb_ack_o = m_ack_i & ~timeout;
        iwb_err_o = m_err_i | timeout;
        grant_o   = 2'b01;
      end
      StGrantD: begin
        m_adr_o   = dwb_adr_i;
        m_dat_o   = dwb_dat_i;
        m_we_o    = dwb_we_i;
        m_sel_o   = dwb_sel_i;
        m_cyc_o   = dwb_cyc_i;
        g_stb     = dwb_stb_i;
        dwb_ack_o = m_ack_i & ~timeout;
        dwb_err_o = m_err_i | timeout;
        grant_o   = 2'b10;
      end
      default: ;
    endcase
  end

  // The strobe is withheld in the abort cycle so memory cannot start a late access.
  assign m_stb_o   = g_stb & ~timeout;
  assign iwb_dat_o = m_dat_i;
  assign dwb_dat_o = m_dat_i;

  // Watchdog: count stalled strobe cycles, clear on any response or grant change.
  always_comb begin
    wdt_d = wdt_q;
    if ((state_q == StIdle) || (state_d != state_q) || timeout || m_ack_i || m_err_i) begin
      wdt_d = '0;
    end else if (WdtEn && g_stb) begin
      wdt_d = wdt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_unified_mem_arbiter.sv
// Directed bench for wb_unified_mem_arbiter (watchdog set to 8 cycles).
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_wb_unified_mem_arbiter;

  logic        clk, rst;
  logic [31:0] iwb_adr_i, iwb_dat_o;
  logic        iwb_cyc_i, iwb_stb_i, iwb_ack_o, iwb_err_o;
  logic [31:0] dwb_adr_i, dwb_dat_i, dwb_dat_o;
  logic        dwb_we_i, dwb_cyc_i, dwb_stb_i, dwb_ack_o, dwb_err_o;
  logic [3:0]  dwb_sel_i, m_sel_o;
  logic [31:0] m_adr_o, m_dat_o, m_dat_i;
  logic        m_we_o, m_cyc_o, m_stb_o, m_ack_i, m_err_i;
  logic [1:0]  grant_o;

  int checks = 0;
  int errors = 0;

  wb_unified_mem_arbiter #(
    .ADDR_W        (32),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .iwb_adr_i(iwb_adr_i),
    .iwb_cyc_i(iwb_cyc_i),
    .iwb_stb_i(iwb_stb_i),
    .iwb_dat_o(iwb_dat_o),
    .iwb_ack_o(iwb_ack_o),
    .iwb_err_o(iwb_err_o),
    .dwb_adr_i(dwb_adr_i),
    .dwb_dat_i(dwb_dat_i),
    .dwb_we_i (dwb_we_i),
    .dwb_sel_i(dwb_sel_i),
    .dwb_cyc_i(dwb_cyc_i),
    .dwb_stb_i(dwb_stb_i),
    .dwb_dat_o(dwb_dat_o),
    .dwb_ack_o(dwb_ack_o),
    .dwb_err_o(dwb_err_o),
    .m_adr_o  (m_adr_o),
    .m_dat_o  (m_dat_o),
    .m_we_o   (m_we_o),
    .m_sel_o  (m_sel_o),
    .m_cyc_o  (m_cyc_o),
    .m_stb_o  (m_stb_o),
    .m_dat_i  (m_dat_i),
    .m_ack_i  (m_ack_i),
    .m_err_i  (m_err_i),
    .grant_o  (grant_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    #1;
    checks++;
    if (m_cyc_o !== 1'b0 || m_stb_o !== 1'b0 || m_we_o !== 1'b0 || m_sel_o !== 4'h0) begin
      errors++;
      $display("FAIL reset_mem: cyc=%b stb=%b we=%b sel=%h, want 0 0 0 0",
               m_cyc_o, m_stb_o, m_we_o, m_sel_o);
    end
    checks++;
    if ({grant_o, iwb_ack_o, iwb_err_o, dwb_ack_o, dwb_err_o} !== 6'b0) begin
      errors++;
      $display("FAIL reset_resp: grant=%b ia=%b ie=%b da=%b de=%b, want all 0",
               grant_o, iwb_ack_o, iwb_err_o, dwb_ack_o, dwb_err_o);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_iwb_fetch();
    @(negedge clk);
    iwb_adr_i = 32'h8000_0000; iwb_cyc_i = 1'b1; iwb_stb_i = 1'b1;
    #1;
    checks++;
    if (m_cyc_o !== 1'b0 || grant_o !== 2'b00) begin
      errors++;
      $display("FAIL fetch_latency: m_cyc=%b grant=%b, want 0 00", m_cyc_o, grant_o);
    end
    @(negedge clk); #1;
    checks++;
    if (m_cyc_o !== 1'b1 || m_stb_o !== 1'b1 || grant_o !== 2'b01 ||
        m_adr_o !== 32'h8000_0000 || m_we_o !== 1'b0 || m_sel_o !== 4'hF) begin
      errors++;
      $display("FAIL fetch_grant: cyc=%b stb=%b grant=%b adr=%h we=%b sel=%h, want 1 1 01 80000000 0 f",
               m_cyc_o, m_stb_o, grant_o, m_adr_o, m_we_o, m_sel_o);
    end
    @(negedge clk); #1;
    checks++;
    if (iwb_ack_o !== 1'b0) begin
      errors++;
      $display("FAIL fetch_early_ack: iwb_ack=%b, want 0", iwb_ack_o);
    end
    @(negedge clk);
    m_ack_i = 1'b1; m_dat_i = 32'h0000_0013;
    #1;
    checks++;
    if (iwb_ack_o !== 1'b1 || iwb_dat_o !== 32'h0000_0013 || dwb_ack_o !== 1'b0) begin
      errors++;
      $display("FAIL fetch_ack: iwb_ack=%b dat=%h dwb_ack=%b, want 1 00000013 0",
               iwb_ack_o, iwb_dat_o, dwb_ack_o);
    end
    @(negedge clk);
    m_ack_i = 1'b0; iwb_cyc_i = 1'b0; iwb_stb_i = 1'b0;
    #1;
    checks++;
    if (m_cyc_o !== 1'b0) begin
      errors++;
      $display("FAIL fetch_release_comb: m_cyc=%b, want 0", m_cyc_o);
    end
    @(negedge clk); #1;
    checks++;
    if (grant_o !== 2'b00) begin
      errors++;
      $display("FAIL fetch_idle: grant=%b, want 00", grant_o);
    end
  endtask

  task automatic test_tie();
    @(negedge clk);
    iwb_adr_i = 32'h8000_0000; iwb_cyc_i = 1'b1; iwb_stb_i = 1'b1;
    dwb_adr_i = 32'h8000_1000; dwb_dat_i = 32'hDEAD_BEEF; dwb_we_i = 1'b1;
    dwb_sel_i = 4'b0011; dwb_cyc_i = 1'b1; dwb_stb_i = 1'b1;
    @(negedge clk);
    m_ack_i = 1'b1;
    #1;
    checks++;
    if (grant_o !== 2'b10 || m_adr_o !== 32'h8000_1000 || m_dat_o !== 32'hDEAD_BEEF ||
        m_we_o !== 1'b1 || m_sel_o !== 4'b0011) begin
      errors++;
      $display("FAIL tie_dwb_first: grant=%b adr=%h dat=%h we=%b sel=%b, want 10 80001000 deadbeef 1 0011",
               grant_o, m_adr_o, m_dat_o, m_we_o, m_sel_o);
    end
    checks++;
    if (dwb_ack_o !== 1'b1 || iwb_ack_o !== 1'b0) begin
      errors++;
      $display("FAIL tie_ack_route: dwb_ack=%b iwb_ack=%b, want 1 0", dwb_ack_o, iwb_ack_o);
    end
    @(negedge clk);
    m_ack_i = 1'b0; dwb_cyc_i = 1'b0; dwb_stb_i = 1'b0; dwb_we_i = 1'b0;
    #1;
    checks++;
    if (grant_o !== 2'b10 || m_cyc_o !== 1'b0) begin
      errors++;
      $display("FAIL tie_release: grant=%b m_cyc=%b, want 10 0", grant_o, m_cyc_o);
    end
    @(negedge clk); #1;
    checks++;
    if (grant_o !== 2'b01 || m_cyc_o !== 1'b1 || m_adr_o !== 32'h8000_0000) begin
      errors++;
      $display("FAIL tie_handover: grant=%b m_cyc=%b adr=%h, want 01 1 80000000",
               grant_o, m_cyc_o, m_adr_o);
    end
    @(negedge clk);
    iwb_cyc_i = 1'b0; iwb_stb_i = 1'b0;
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    dwb_adr_i = 32'h8000_2000; dwb_we_i = 1'b0; dwb_sel_i = 4'hF;
    dwb_cyc_i = 1'b1; dwb_stb_i = 1'b1;
    @(negedge clk);
    iwb_adr_i = 32'h8000_0004; iwb_cyc_i = 1'b1; iwb_stb_i = 1'b1;
    m_ack_i = 1'b1; m_dat_i = 32'h1111_1111;
    #1;
    checks++;
    if (grant_o !== 2'b10 || dwb_ack_o !== 1'b1 || dwb_dat_o !== 32'h1111_1111 ||
        iwb_ack_o !== 1'b0) begin
      errors++;
      $display("FAIL b2b_load1: grant=%b dwb_ack=%b dat=%h iwb_ack=%b, want 10 1 11111111 0",
               grant_o, dwb_ack_o, dwb_dat_o, iwb_ack_o);
    end
    @(negedge clk);
    m_ack_i = 1'b0; dwb_stb_i = 1'b0;
    #1;
    checks++;
    if (grant_o !== 2'b10 || m_cyc_o !== 1'b1 || m_stb_o !== 1'b0) begin
      errors++;
      $display("FAIL b2b_gap: grant=%b m_cyc=%b m_stb=%b, want 10 1 0", grant_o, m_cyc_o, m_stb_o);
    end
    @(negedge clk);
    dwb_adr_i = 32'h8000_2004; dwb_stb_i = 1'b1; m_ack_i = 1'b1; m_dat_i = 32'h2222_2222;
    #1;
    checks++;
    if (grant_o !== 2'b10 || m_adr_o !== 32'h8000_2004 || dwb_ack_o !== 1'b1 ||
        iwb_ack_o !== 1'b0) begin
      errors++;
      $display("FAIL b2b_load2: grant=%b adr=%h dwb_ack=%b iwb_ack=%b, want 10 80002004 1 0",
               grant_o, m_adr_o, dwb_ack_o, iwb_ack_o);
    end
    @(negedge clk);
    m_ack_i = 1'b0; dwb_cyc_i = 1'b0; dwb_stb_i = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (grant_o !== 2'b01 || m_adr_o !== 32'h8000_0004) begin
      errors++;
      $display("FAIL b2b_iwb_after: grant=%b adr=%h, want 01 80000004", grant_o, m_adr_o);
    end
    @(negedge clk);
    iwb_cyc_i = 1'b0; iwb_stb_i = 1'b0;
  endtask

  // dwb is granted alone first, so a following tie separates the two policies.
  task automatic test_tie_after_dwb();
    logic [1:0] want;
`ifdef ARB_ROUND_ROBIN_EN
    want = 2'b01;
`else
    want = 2'b10;
`endif
    @(negedge clk);
    dwb_adr_i = 32'h8000_3000; dwb_we_i = 1'b0; dwb_cyc_i = 1'b1; dwb_stb_i = 1'b1;
    @(negedge clk);
    m_ack_i = 1'b1;
    @(negedge clk);
    m_ack_i = 1'b0; dwb_cyc_i = 1'b0; dwb_stb_i = 1'b0;
    @(negedge clk);
    dwb_cyc_i = 1'b1; dwb_stb_i = 1'b1; iwb_cyc_i = 1'b1; iwb_stb_i = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (grant_o !== want) begin
      errors++;
      $display("FAIL second_tie: grant=%b, want %b", grant_o, want);
    end
    @(negedge clk);
    dwb_cyc_i = 1'b0; dwb_stb_i = 1'b0; iwb_cyc_i = 1'b0; iwb_stb_i = 1'b0;
  endtask

  task automatic test_watchdog();
    int n_err = 0;
    int err_at = 0;
    logic stb_at_err = 1'b1;
    logic stb_before = 1'b0;
    @(negedge clk);
    dwb_adr_i = 32'h8000_4000; dwb_we_i = 1'b0; dwb_cyc_i = 1'b1; dwb_stb_i = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk); #1;
      if (k == 8) stb_before = m_stb_o;
      if (dwb_err_o === 1'b1) begin
        n_err++;
        err_at = k;
        stb_at_err = m_stb_o;
      end
    end
    checks++;
    if (n_err != 1 || err_at != 9) begin
      errors++;
      $display("FAIL wdt_pulse: pulses=%0d at grant cycle %0d, want 1 at 9", n_err, err_at);
    end
    checks++;
    if (stb_at_err !== 1'b0 || stb_before !== 1'b1) begin
      errors++;
      $display("FAIL wdt_stb: stb at err=%b before=%b, want 0 1", stb_at_err, stb_before);
    end
    @(negedge clk);
    dwb_cyc_i = 1'b0; dwb_stb_i = 1'b0;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    dwb_adr_i = 32'h8000_5000; dwb_we_i = 1'b1; dwb_cyc_i = 1'b1; dwb_stb_i = 1'b1;
    @(negedge clk);
    m_ack_i = 1'b1;
    #1;
    checks++;
    if (grant_o !== 2'b10 || dwb_ack_o !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_pre: grant=%b dwb_ack=%b, want 10 1", grant_o, dwb_ack_o);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (m_cyc_o !== 1'b0 || m_stb_o !== 1'b0 || grant_o !== 2'b00 || dwb_ack_o !== 1'b0 ||
        iwb_ack_o !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_async: cyc=%b stb=%b grant=%b da=%b ia=%b, want all 0",
               m_cyc_o, m_stb_o, grant_o, dwb_ack_o, iwb_ack_o);
    end
    @(negedge clk);
    rst = 1'b0; m_ack_i = 1'b0; dwb_cyc_i = 1'b0; dwb_stb_i = 1'b0; dwb_we_i = 1'b0;
    @(negedge clk);
    iwb_adr_i = 32'h8000_0008; iwb_cyc_i = 1'b1; iwb_stb_i = 1'b1;
    #1;
    checks++;
    if (grant_o !== 2'b00) begin
      errors++;
      $display("FAIL rstmid_latency: grant=%b, want 00", grant_o);
    end
    @(negedge clk); #1;
    checks++;
    if (grant_o !== 2'b01 || m_cyc_o !== 1'b1 || m_adr_o !== 32'h8000_0008) begin
      errors++;
      $display("FAIL rstmid_regrant: grant=%b cyc=%b adr=%h, want 01 1 80000008",
               grant_o, m_cyc_o, m_adr_o);
    end
    @(negedge clk);
    iwb_cyc_i = 1'b0; iwb_stb_i = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    iwb_adr_i = '0; iwb_cyc_i = 1'b0; iwb_stb_i = 1'b0;
    dwb_adr_i = '0; dwb_dat_i = '0; dwb_we_i = 1'b0; dwb_sel_i = 4'h0;
    dwb_cyc_i = 1'b0; dwb_stb_i = 1'b0;
    m_dat_i = '0; m_ack_i = 1'b0; m_err_i = 1'b0;
    test_reset();
    test_iwb_fetch();
    test_tie();
    test_back_to_back();
    test_tie_after_dwb();
    test_watchdog();
    test_reset_mid();
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_unified_mem_arbiter.md
Name: wb_unified_mem_arbiter

Overview:
- Shares one Wishbone slave port (the unified code+data memory) between custom_riscv_core's instruction bus (iwb) and data bus (dwb).
- Grant-based, cycle-locked arbitration; a transfer is never interrupted once granted.
- Includes a bus-hang watchdog that terminates stalled transfers with an error.
- Sits between core and memory in SoC top and in compliance benches; makes self-modifying code and FENCE.I coherent by construction.

Parameters:
- ADDR_W, 32, address width of all ports.
- TIMEOUT_CYCLES, 256, stalled-strobe cycles before watchdog error; 0 disables the watchdog.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- iwb_adr_i  in  ADDR_W  instruction fetch address
- iwb_cyc_i  in  1  instruction cycle
- iwb_stb_i  in  1  instruction strobe
- iwb_dat_o  out  32  fetched word
- iwb_ack_o  out  1  instruction ack
- iwb_err_o  out  1  instruction error
- dwb_adr_i  in  ADDR_W  data address
- dwb_dat_i  in  32  store data
- dwb_we_i  in  1  write enable
- dwb_sel_i  in  4  byte selects
- dwb_cyc_i  in  1  data cycle
- dwb_stb_i  in  1  data strobe
- dwb_dat_o  out  32  load data
- dwb_ack_o  out  1  data ack
- dwb_err_o  out  1  data error
- m_adr_o  out  ADDR_W  memory address
- m_dat_o  out  32  memory write data
- m_we_o  out  1  memory write enable
- m_sel_o  out  4  memory byte selects
- m_cyc_o  out  1  memory cycle
- m_stb_o  out  1  memory strobe
- m_dat_i  in  32  memory read data
- m_ack_i  in  1  memory ack
- m_err_i  in  1  memory error
- grant_o  out  2  {dwb granted, iwb granted}, one-hot or zero

Behaviour:
- FSM states: IDLE, GRANT_I, GRANT_D; state register only, reset asynchronously to IDLE.
- Reset values (reset forces IDLE):
  - m_cyc_o, m_stb_o, m_we_o = 0; m_sel_o = 0.
  - All ack/err outputs = 0; grant_o = 2'b00.
  - Watchdog counter = 0.
- Request: a master requests when cyc_i & stb_i.
- IDLE:
  - Only one master requesting: go to that grant next cycle.
  - Both requesting: dwb wins (fixed priority).
  - Arbitration latency is exactly one cycle; IDLE drives nothing to memory.
- GRANT_x:
  - Granted master's adr/cyc/stb are passed combinationally to m_*.
  - GRANT_I forces m_we_o=0, m_sel_o=4'hF, m_dat_o=0.
  - GRANT_D passes dat/we/sel unchanged.
  - m_dat_i is routed to both dat_o ports; m_ack_i/m_err_i go to the granted master only. The non-granted master sees ack=err=0 and simply waits.
- Release:
  - Grant holds while the granted master's cyc_i=1, including across multiple strobes.
  - In the cycle cyc_i=0: if the other master requests, switch directly to its grant (no IDLE bubble); else go to IDLE.
  - Release is evaluated combinationally: m_cyc_o drops in the same cycle cyc_i drops.
- Watchdog (TIMEOUT_CYCLES>0):
  - Counter increments each GRANT cycle with stb high and no m_ack_i/m_err_i; clears on ack, err or state change.
  - On reaching TIMEOUT_CYCLES: assert err_o to the granted master for exactly one cycle, hold m_stb_o low that cycle, clear counter.
  - Counter width is $clog2(TIMEOUT_CYCLES+1).
- Simultaneous m_ack_i and m_err_i: both are forwarded; master treats err as dominant.
- Reset asserted mid-transfer: outputs zero immediately (async); the pending transfer is abandoned, with no ack generated.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined:
  - On simultaneous requests in IDLE or at release, the master not granted last wins.
  - A 1-bit last_grant register resets to iwb, so dwb wins the first tie.
- Undefined: fixed priority, dwb always wins ties; no last_grant register.

Test Plan:
- iwb only, fetch 0x80000000, memory acks after 2 cycles with 0x00000013:
  - m_cyc_o rises 1 cycle after request; iwb_ack_o with iwb_dat_o=0x00000013; m_we_o=0, m_sel_o=4'hF.
  - dwb_ack_o stays 0 throughout.
- Both request same cycle, dwb store 0xDEADBEEF sel=4'b0011 to 0x80001000:
  - grant_o=2'b10 first, then 2'b01 immediately after dwb_cyc_i drops.
  - Under ARB_ROUND_ROBIN_EN, a second tie grants iwb first.
- dwb holds cyc across two back-to-back loads while iwb requests:
  - iwb gets no grant until dwb_cyc_i=0; iwb_ack_o=0 meanwhile.
- TIMEOUT_CYCLES=8, memory never acks a dwb load:
  - dwb_err_o pulses exactly once, 8 cycles after grant; m_stb_o=0 that cycle.
- rst asserted during a GRANT_D transfer:
  - m_cyc_o, grant_o and all acks go to 0 asynchronously.
  - After release, a new iwb request is granted normally in 1 cycle.
